// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// Covers access sizes, FSM states, requester ids and IO address decode.
package mem_ctrl_pkg;

  localparam logic [1:0] IO_HI_BITS = 2'b11;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  typedef enum logic {
    REQ_IC,
    REQ_LSB
  } req_t;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == IO_HI_BITS;
  endfunction

  // The illegal size encoding 3 is handled as a full word.
  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = word >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundles the ICache, LSB and RAM/IO port signals of the memory controller.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_ctrl_if;
  logic        ic_valid;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic [31:0] ic_data;

  logic        lsb_valid;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_ready;
  logic [31:0] lsb_rdata;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  ic_valid, ic_addr, lsb_valid, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           mem_din, io_buffer_full,
    output ic_ready, ic_data, lsb_ready, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output ic_valid, ic_addr, lsb_valid, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           mem_din, io_buffer_full,
    input  ic_ready, ic_data, lsb_ready, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates ICache and LSB onto the byte-wide RAM/IO port and sequences each
// access one byte per cycle, little-endian, with round-robin on simultaneous requests.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);

  state_t      state;
  req_t        owner;
  req_t        last_grant;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;

  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        ic_ready_q;
  logic        lsb_ready_q;
  logic [31:0] ic_data_q;
  logic [31:0] lsb_rdata_q;

  logic        ic_elig;
  logic        lsb_elig;
  logic        grant_ic;
  logic [31:0] req_addr;
  logic [31:0] cur_addr;
  logic [31:0] rbuf_next;
  logic [2:0]  cap_cnt;
  logic        accept_stall;
  logic        cur_stall;

  // A requester whose ready pulse is showing is still holding valid, so it is
  // excluded for that cycle to avoid serving the same request twice.
  always_comb begin
    ic_elig  = bus.ic_valid && !ic_ready_q;
    lsb_elig = bus.lsb_valid && !lsb_ready_q;
    if (ic_elig && lsb_elig) grant_ic = (last_grant == REQ_LSB);
    else                     grant_ic = ic_elig;
    req_addr     = grant_ic ? bus.ic_addr : bus.lsb_addr;
    cur_addr     = addr + {29'd0, cnt};
    accept_stall = is_io(bus.lsb_addr) && bus.io_buffer_full;
    cur_stall    = is_io(cur_addr) && bus.io_buffer_full;
    cap_cnt      = cnt - 3'd2;
    rbuf_next    = rbuf | ({24'd0, bus.mem_din} << {cap_cnt[1:0], 3'b000});
  end

  // In READ, cnt counts edges since accept: the address for byte cnt goes out
  // while the byte addressed two edges earlier is captured from mem_din.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= REQ_IC;
      last_grant  <= REQ_IC;
      cnt         <= 3'd0;
      len         <= 3'd0;
      addr        <= '0;
      wdata       <= '0;
      rbuf        <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      ic_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      ic_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      ic_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ic_elig || lsb_elig) begin
            addr    <= req_addr;
            mem_a_q <= req_addr;
            rbuf    <= '0;
            if (ic_elig && lsb_elig) last_grant <= grant_ic ? REQ_IC : REQ_LSB;
            if (grant_ic) begin
              owner <= REQ_IC;
              len   <= 3'd4;
              cnt   <= 3'd1;
              state <= READ;
            end else begin
              owner <= REQ_LSB;
              len   <= size_len(bus.lsb_size);
              wdata <= bus.lsb_wdata;
              if (bus.lsb_wr) begin
                state      <= WRITE;
                mem_dout_q <= bus.lsb_wdata[7:0];
                mem_wr_q   <= !accept_stall;
                cnt        <= accept_stall ? 3'd0 : 3'd1;
              end else begin
                state <= READ;
                cnt   <= 3'd1;
              end
            end
          end
        end

        READ: begin
          cnt     <= cnt + 3'd1;
          mem_a_q <= (cnt < len) ? cur_addr : '0;
          if (cnt >= 3'd2) rbuf <= rbuf_next;
          if (cnt > len) begin
            state <= IDLE;
            if (owner == REQ_IC) begin
              ic_ready_q <= 1'b1;
              ic_data_q  <= rbuf_next;
            end else begin
              lsb_ready_q <= 1'b1;
              lsb_rdata_q <= rbuf_next;
            end
          end
        end

        // A full IO buffer re-presents the same byte with mem_wr low until it drains.
        WRITE: begin
          if (cnt < len) begin
            mem_a_q    <= cur_addr;
            mem_dout_q <= byte_sel(wdata, cnt[1:0]);
            mem_wr_q   <= !cur_stall;
            if (!cur_stall) cnt <= cnt + 3'd1;
          end else begin
            mem_a_q     <= '0;
            mem_wr_q    <= 1'b0;
            lsb_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ic_ready  = ic_ready_q;
  assign bus.ic_data   = ic_data_q;
  assign bus.lsb_ready = lsb_ready_q;
  assign bus.lsb_rdata = lsb_rdata_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a table of single LSB accesses plus hand-written
// sequences for arbitration, IO back-pressure, rdy freeze and mid-access reset.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  logic rdy;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte RAM with one cycle of read latency; a few locations are seeded under reset.
  logic [7:0] ram [0:262143];

  always @(posedge clk) begin
    if (rst) begin
      ram[18'h00100] <= 8'h13;
      ram[18'h00101] <= 8'h05;
      ram[18'h00102] <= 8'h00;
      ram[18'h00103] <= 8'h00;
      ram[18'h00202] <= 8'h80;
      ram[18'h00203] <= 8'hFF;
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[17:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[17:0]];
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nbytes;
    int          exp_cyc;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  int n_pass;
  int n_total;

  int          ic_cyc, lsb_cyc, ic_pulses, lsb_pulses, wr_total;
  logic [31:0] ic_got, lsb_got;
  logic        wr_hist   [0:31];
  logic [31:0] a_hist    [0:31];
  logic [7:0]  dout_hist [0:31];
  int          full_end, rdy_lo_start, rdy_lo_end, rst_at;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
    bus.lsb_valid = 1'b1;
    bus.lsb_wr    = wr;
    bus.lsb_size  = size;
    bus.lsb_addr  = addr;
    bus.lsb_wdata = wdata;
  endtask

  // Cycle k is sampled on the falling edge after the k-th rising edge counted
  // from the accept edge; valids drop as soon as their ready pulse is seen.
  task automatic run_cycles(input int budget);
    ic_cyc = 0; lsb_cyc = 0; ic_pulses = 0; lsb_pulses = 0; wr_total = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      wr_hist[k]   = bus.mem_wr;
      a_hist[k]    = bus.mem_a;
      dout_hist[k] = bus.mem_dout;
      if (bus.mem_wr) wr_total++;
      if (bus.ic_ready) begin
        ic_pulses++;
        if (ic_cyc == 0) begin ic_cyc = k; ic_got = bus.ic_data; end
        bus.ic_valid = 1'b0;
      end
      if (bus.lsb_ready) begin
        lsb_pulses++;
        if (lsb_cyc == 0) begin lsb_cyc = k; lsb_got = bus.lsb_rdata; end
        bus.lsb_valid = 1'b0;
      end
      if (k == full_end) bus.io_buffer_full = 1'b0;
      rdy = !(k >= rdy_lo_start && k < rdy_lo_end);
      if (rst_at != 0 && k == rst_at) begin rst = 1'b1; bus.lsb_valid = 1'b0; end
      if (rst_at != 0 && k == rst_at + 1) rst = 1'b0;
    end
    full_end = 0; rdy_lo_start = 0; rdy_lo_end = 0; rst_at = 0;
  endtask

  initial begin
    logic [31:0] wd;
    clk = 1'b0; rst = 1'b1; rdy = 1'b1;
    n_pass = 0; n_total = 0;
    full_end = 0; rdy_lo_start = 0; rdy_lo_end = 0; rst_at = 0;
    bus.ic_valid = 1'b0; bus.ic_addr = '0;
    bus.lsb_valid = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_size = '0;
    bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.io_buffer_full = 1'b0;

    vecs[0]  = '{1'b0, 2'd1, 32'h0000_0202, 32'h0,         2, 4, 32'h0000_FF80};
    vecs[1]  = '{1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF, 4, 5, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 32'h0000_0200, 32'h0,         4, 6, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 2'd0, 32'h0000_0203, 32'h0,         1, 3, 32'h0000_00DE};
    vecs[4]  = '{1'b1, 2'd0, 32'h0000_0400, 32'hFFFF_FF41, 1, 2, 32'h0};
    vecs[5]  = '{1'b1, 2'd1, 32'h0000_0402, 32'h1234_CAFE, 2, 3, 32'h0};
    vecs[6]  = '{1'b1, 2'd0, 32'h0000_0401, 32'h0000_005A, 1, 2, 32'h0};
    vecs[7]  = '{1'b0, 2'd2, 32'h0000_0400, 32'h0,         4, 6, 32'hCAFE_5A41};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_0404, 32'h1234_5678, 4, 5, 32'h0};
    vecs[9]  = '{1'b0, 2'd3, 32'h0000_0404, 32'h0,         4, 6, 32'h1234_5678};
    vecs[10] = '{1'b0, 2'd1, 32'h0000_0406, 32'h0,         2, 4, 32'h0000_1234};
    vecs[11] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, 2, 3, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    check_output("rst_ic_ready",  32'(bus.ic_ready), 32'h0);
    check_output("rst_lsb_ready", 32'(bus.lsb_ready), 32'h0);
    check_output("rst_mem_wr",    32'(bus.mem_wr), 32'h0);
    check_output("rst_mem_a",     bus.mem_a, 32'h0);
    check_output("rst_mem_dout",  32'(bus.mem_dout), 32'h0);
    check_output("rst_ic_data",   bus.ic_data, 32'h0);
    check_output("rst_lsb_rdata", bus.lsb_rdata, 32'h0);

    $display("[TB] icache word fetch");
    bus.ic_valid = 1'b1; bus.ic_addr = 32'h0000_0100;
    run_cycles(10);
    check_output("ic_fetch_cycle",  ic_cyc, 6);
    check_output("ic_fetch_data",   ic_got, 32'h0000_0513);
    check_output("ic_fetch_pulses", ic_pulses, 1);
    check_output("ic_fetch_writes", wr_total, 0);

    $display("[TB] lsb vector table");
    for (int v = 0; v < 12; v++) begin
      apply_stimulus(vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata);
      run_cycles(10);
      check_output($sformatf("vec%0d_cycle", v), lsb_cyc, vecs[v].exp_cyc);
      check_output($sformatf("vec%0d_pulses", v), lsb_pulses, 1);
      if (vecs[v].wr) begin
        check_output($sformatf("vec%0d_writes", v), wr_total, vecs[v].nbytes);
        for (int i = 0; i < vecs[v].nbytes; i++) begin
          wd = vecs[v].wdata >> (8 * i);
          check_output($sformatf("vec%0d_wr%0d", v, i), 32'(wr_hist[i + 1]), 32'h1);
          check_output($sformatf("vec%0d_a%0d", v, i), a_hist[i + 1], vecs[v].addr + 32'(i));
          check_output($sformatf("vec%0d_d%0d", v, i), 32'(dout_hist[i + 1]), {24'd0, wd[7:0]});
        end
      end else begin
        check_output($sformatf("vec%0d_rdata", v), lsb_got, vecs[v].exp_rdata);
        check_output($sformatf("vec%0d_writes", v), wr_total, 0);
      end
    end

    $display("[TB] half load with rdy low two cycles");
    apply_stimulus(1'b0, 2'd1, 32'h0000_0202, 32'h0);
    rdy_lo_start = 1; rdy_lo_end = 3;
    run_cycles(10);
    check_output("rdy_load_cycle", lsb_cyc, 6);
    check_output("rdy_load_data",  lsb_got, 32'h0000_DEAD);

    $display("[TB] first tie goes to the lsb");
    bus.ic_valid = 1'b1; bus.ic_addr = 32'h0000_0200;
    apply_stimulus(1'b0, 2'd2, 32'h0000_0404, 32'h0);
    run_cycles(16);
    check_output("tie1_lsb_cycle", lsb_cyc, 6);
    check_output("tie1_lsb_data",  lsb_got, 32'h1234_5678);
    check_output("tie1_ic_cycle",  ic_cyc, 12);
    check_output("tie1_ic_data",   ic_got, 32'hDEAD_BEEF);

    $display("[TB] second tie goes to the icache");
    bus.ic_valid = 1'b1; bus.ic_addr = 32'h0000_0404;
    apply_stimulus(1'b0, 2'd0, 32'h0000_0100, 32'h0);
    run_cycles(16);
    check_output("tie2_ic_cycle",  ic_cyc, 6);
    check_output("tie2_ic_data",   ic_got, 32'h1234_5678);
    check_output("tie2_lsb_cycle", lsb_cyc, 9);
    check_output("tie2_lsb_data",  lsb_got, 32'h0000_0013);

    $display("[TB] io store with buffer full three cycles");
    apply_stimulus(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
    bus.io_buffer_full = 1'b1;
    full_end = 3;
    run_cycles(10);
    check_output("io_writes",  wr_total, 1);
    check_output("io_wr_c4",   32'(wr_hist[4]), 32'h1);
    check_output("io_a_c4",    a_hist[4], 32'h0003_0000);
    check_output("io_d_c4",    32'(dout_hist[4]), 32'h41);
    check_output("io_ready",   lsb_cyc, 5);

    $display("[TB] reset in the middle of a word store");
    apply_stimulus(1'b1, 2'd2, 32'h0000_0500, 32'h1122_3344);
    rst_at = 2;
    run_cycles(12);
    check_output("rst_mid_writes", wr_total, 2);
    check_output("rst_mid_pulses", lsb_pulses, 0);
    check_output("rst_mid_rdata",  bus.lsb_rdata, 32'h0);
    apply_stimulus(1'b0, 2'd0, 32'h0000_0100, 32'h0);
    run_cycles(8);
    check_output("post_rst_cycle", lsb_cyc, 3);
    check_output("post_rst_data",  lsb_got, 32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
